// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder:
//   state_e    - responder FSM states (IDLE, WAIT, RESP)
//   addr_bits  - ceil(log2(n)), used to size the array index and the
//                latency counter
// Optional feature macro used by the files importing this package:
//   DMEM_OOB_ERR_EN
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // ceil(log2(n)); returns 0 for n <= 1. Bounded loop keeps it synthesizable.
  function automatic int addr_bits(input int n);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bus between an initiator (master) and the data-memory
// responder (slave).
//
// Handshake: a transfer on either channel happens on a rising clk edge where
// the channel's valid and ready are both high. The responder raises req_ready
// only while it has no request outstanding, and once rsp_valid is high it
// holds rsp_valid/rsp_rdata/rsp_err unchanged until the edge on which
// rsp_ready is sampled high.
//
// Signals:
//   req_valid, req_write, req_addr, req_wdata  initiator -> responder
//   req_ready                                  responder -> initiator
//   rsp_valid, rsp_rdata [, rsp_err]           responder -> initiator
//   rsp_ready                                  initiator -> responder
// rsp_err exists only when DMEM_OOB_ERR_EN is defined.
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
  parameter int REG_BITS = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [REG_BITS-1:0] req_addr;
  logic [REG_BITS-1:0] req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [REG_BITS-1:0] rsp_rdata;
`ifdef DMEM_OOB_ERR_EN
  logic                rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`else
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
`endif
endinterface

// File: rtl/dmem_wait_counter.sv
// -----------------------------------------------------------------------------
// dmem_wait_counter
// Down-counter that times the gap between request accept and response.
//   clk, rst_n  clock, asynchronous active-low reset (count -> 0)
//   load        load load_val (has priority over dec)
//   load_val    value loaded on accept
//   dec         decrement by one; saturates at zero
//   zero        count == 0
// -----------------------------------------------------------------------------
module dmem_wait_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding load/store responder in front of a word array.
// A request accepted in IDLE waits LATENCY cycles (WAIT), then the array is
// written (stores) or read (loads) on the edge leaving WAIT and the result is
// held in RESP until the initiator takes it.
//
// Parameters:
//   REG_BITS  data/address width (16 or 32)
//   DEPTH     number of words (power of two, >= 2)
//   LATENCY   cycles from accept edge to rsp_valid (>= 1)
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        dmem_responder_if.slave (request/response channels)
//   dbg_state  current FSM state
// Optional feature: DMEM_OOB_ERR_EN - addresses >= DEPTH are flagged with
//   rsp_err, their stores are dropped and loads return zero. Without it the
//   address wraps modulo DEPTH.
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int REG_BITS = 32,
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus,
  output state_e          dbg_state
);

  localparam int AW = addr_bits(DEPTH);
  // Counter only ever holds LATENCY-1; keep at least one bit.
  localparam int CW = (LATENCY > 1) ? addr_bits(LATENCY) : 1;

  state_e state, state_nxt;

  logic                req_ready_c;
  logic                rsp_valid_c;
  logic                cnt_load;
  logic                cnt_dec;
  logic                cnt_zero;
  logic                wait_done;
  logic                addr_hi;
  logic                oob;
  logic                mem_we;

  logic                cap_write;
  logic [REG_BITS-1:0] cap_addr;
  logic [REG_BITS-1:0] cap_wdata;
  logic [AW-1:0]       idx;

  logic [REG_BITS-1:0] rsp_rdata_q;
  logic                rsp_err_q;

  // Contents are deliberately not reset.
  logic [REG_BITS-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          cnt_load  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt_zero) state_nxt = RESP;
        else          cnt_dec   = 1'b1;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wait_done = (state == WAIT) && cnt_zero;

  dmem_wait_counter #(
    .WIDTH(CW)
  ) u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CW'(LATENCY - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (cnt_load) begin
      cap_write <= bus.req_write;
      cap_addr  <= bus.req_addr;
      cap_wdata <= bus.req_wdata;
    end
  end

  assign idx     = cap_addr[AW-1:0];
  // Any address bit at or above log2(DEPTH) set means address >= DEPTH.
  assign addr_hi = |(cap_addr >> AW);

`ifdef DMEM_OOB_ERR_EN
  assign oob = addr_hi;
`else
  // Upper bits are simply dropped (modulo-DEPTH wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = addr_hi;
  assign oob            = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Array access on the edge leaving WAIT
  // ---------------------------------------------------------------------------
  assign mem_we = wait_done && cap_write && !oob;

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= cap_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (wait_done) begin
      // Stores and flagged accesses return zero data.
      rsp_rdata_q <= (cap_write || oob) ? '0 : mem[idx];
      rsp_err_q   <= oob;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_rdata = rsp_rdata_q;
`ifdef DMEM_OOB_ERR_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  logic unused_err;
  assign unused_err = rsp_err_q;
`endif
  assign dbg_state     = state;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders share clk/rst_n:
//   dut_a: REG_BITS=32, DEPTH=256, LATENCY=2
//   dut_b: REG_BITS=16, DEPTH=16,  LATENCY=1
// A word-array model (plus "written" flags, since the array is not reset)
// gives the expected load data; loads of never-written words are not checked.
// Honors DMEM_OOB_ERR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH_A = 256;
  localparam int LAT_A   = 2;
  localparam int DEPTH_B = 16;
  localparam int LAT_B   = 1;
  localparam int TMO     = 50;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.REG_BITS(32)) bus_a ();
  dmem_responder_if #(.REG_BITS(16)) bus_b ();
  state_e dbg_a, dbg_b;

  dmem_responder #(.REG_BITS(32), .DEPTH(DEPTH_A), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .dbg_state(dbg_a)
  );
  dmem_responder #(.REG_BITS(16), .DEPTH(DEPTH_B), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_a [DEPTH_A];
  bit          known_a [DEPTH_A];
  logic [15:0] mem_b [DEPTH_B];
  bit          known_b [DEPTH_B];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: dut_a transaction ----------------
  // Called #1 after a rising edge. hold = cycles rsp_ready stays low in RESP,
  // during which a conflicting store request is presented and must be ignored.
  task automatic txn_a(input bit write, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold);
    int          idx;
    int          cnt;
    bit          oob;
    bit          known;
    logic [31:0] exp_rd;
    logic [31:0] first_rd;
    idx = int'(addr % DEPTH_A);
`ifdef DMEM_OOB_ERR_EN
    oob = (addr >= DEPTH_A);
`else
    oob = 1'b0;
`endif
    if (write || oob) begin exp_rd = '0; known = 1'b1; end
    else begin exp_rd = mem_a[idx]; known = known_a[idx]; end
    if (known) exp_q.push_back(exp_rd);

    bus_a.req_valid = 1'b1;
    bus_a.req_write = write;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    cnt = 0;
    while (!bus_a.req_ready && cnt < TMO) begin @(posedge clk); #1; cnt++; end
    check("a_accept_tmo", 32'(cnt < TMO), 32'd1);
    @(posedge clk); #1;                       // accept edge
    bus_a.req_valid = 1'b0;
    cnt = 0;
    while (!bus_a.rsp_valid && cnt < TMO) begin @(posedge clk); #1; cnt++; end
    check("a_latency", 32'(cnt), 32'(LAT_A));
    first_rd = bus_a.rsp_rdata;
    if (known) check("a_rdata", bus_a.rsp_rdata, exp_q.pop_front());
`ifdef DMEM_OOB_ERR_EN
    check("a_err", 32'(bus_a.rsp_err), 32'(oob));
`endif
    for (int i = 0; i < hold; i++) begin
      bus_a.req_valid = 1'b1;
      bus_a.req_write = 1'b1;
      bus_a.req_addr  = 32'($urandom_range(0, DEPTH_A - 1));
      bus_a.req_wdata = $urandom;
      @(posedge clk); #1;
      check("a_hold_valid", 32'(bus_a.rsp_valid), 32'd1);
      check("a_hold_rdata", bus_a.rsp_rdata, known ? exp_rd : first_rd);
      check("a_hold_req_ready", 32'(bus_a.req_ready), 32'd0);
    end
    bus_a.req_valid = 1'b0;
    bus_a.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.rsp_ready = 1'b0;
    check("a_rsp_done", 32'(bus_a.rsp_valid), 32'd0);
    check("a_idle_ready", 32'(bus_a.req_ready), 32'd1);
    if (write && !oob) begin mem_a[idx] = wdata; known_a[idx] = 1'b1; end
  endtask

  // ---------------- driver: dut_b transaction ----------------
  task automatic txn_b(input bit write, input logic [15:0] addr, input logic [15:0] wdata);
    int          idx;
    int          cnt;
    bit          oob;
    bit          known;
    logic [31:0] exp_rd;
    idx = int'(addr % DEPTH_B);
`ifdef DMEM_OOB_ERR_EN
    oob = (addr >= DEPTH_B);
`else
    oob = 1'b0;
`endif
    if (write || oob) begin exp_rd = '0; known = 1'b1; end
    else begin exp_rd = {16'h0, mem_b[idx]}; known = known_b[idx]; end
    if (known) exp_q.push_back(exp_rd);

    bus_b.req_valid = 1'b1;
    bus_b.req_write = write;
    bus_b.req_addr  = addr;
    bus_b.req_wdata = wdata;
    cnt = 0;
    while (!bus_b.req_ready && cnt < TMO) begin @(posedge clk); #1; cnt++; end
    check("b_accept_tmo", 32'(cnt < TMO), 32'd1);
    @(posedge clk); #1;
    bus_b.req_valid = 1'b0;
    cnt = 0;
    while (!bus_b.rsp_valid && cnt < TMO) begin @(posedge clk); #1; cnt++; end
    check("b_latency", 32'(cnt), 32'(LAT_B));
    if (known) check("b_rdata", {16'h0, bus_b.rsp_rdata}, exp_q.pop_front());
`ifdef DMEM_OOB_ERR_EN
    check("b_err", 32'(bus_b.rsp_err), 32'(oob));
`endif
    bus_b.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus_b.rsp_ready = 1'b0;
    check("b_rsp_done", 32'(bus_b.rsp_valid), 32'd0);
    if (write && !oob) begin mem_b[idx] = wdata; known_b[idx] = 1'b1; end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n_acc;
    int n_rsp;
    int last_c;
    int nxt;
    bit acc;

    bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = '0;
    bus_a.req_wdata = '0;   bus_a.rsp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = '0;
    bus_b.req_wdata = '0;   bus_b.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH_A; i++) known_a[i] = 1'b0;
    for (int i = 0; i < DEPTH_B; i++) known_b[i] = 1'b0;

    // Reset state, before any clock edge.
    #1;
    check("rst_req_ready", 32'(bus_a.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
    check("rst_state", 32'(dbg_a), 32'(IDLE));
    check("rst_b_req_ready", 32'(bus_b.req_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store 0xDEADBEEF to 5, read it back with 2-cycle latency.
    txn_a(1'b1, 32'd5, 32'hDEAD_BEEF, 0);
    txn_a(1'b0, 32'd5, 32'h0, 0);
    // Response held for 4 cycles with rsp_ready low; conflicting request ignored.
    txn_a(1'b0, 32'd5, 32'h0, 4);

    // Out-of-range store 0x1234 to 0x105, then look at word 5.
    txn_a(1'b1, 32'h105, 32'h1234, 0);
    txn_a(1'b0, 32'd5, 32'h0, 0);
    txn_a(1'b0, 32'h105, 32'h0, 0);

    // Reset during WAIT of a store to 7.
    txn_a(1'b1, 32'd7, 32'h1111_1111, 0);
    txn_a(1'b0, 32'd7, 32'h0, 0);           // leaves rsp_rdata non-zero
    bus_a.req_valid = 1'b1;
    bus_a.req_write = 1'b1;
    bus_a.req_addr  = 32'd7;
    bus_a.req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    check("mid_state_wait", 32'(dbg_a), 32'(WAIT));
    check("mid_req_ready", 32'(bus_a.req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req_ready", 32'(bus_a.req_ready), 32'd1);
    check("arst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("arst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
    check("arst_state", 32'(dbg_a), 32'(IDLE));
`ifdef DMEM_OOB_ERR_EN
    check("arst_rsp_err", 32'(bus_a.rsp_err), 32'd0);
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn_a(1'b0, 32'd7, 32'h0, 0);           // model still holds 0x11111111

    // 16-bit instance: store 0xFFFF to 0 and read back.
    txn_b(1'b1, 16'd0, 16'hFFFF);
    txn_b(1'b0, 16'd0, 16'h0);
    for (int i = 1; i < 4; i++) txn_b(1'b1, 16'(i), 16'($urandom));

    // LATENCY=1 back-to-back loads of words 0..3 with rsp_ready tied high.
    nxt = 0; n_acc = 0; n_rsp = 0; last_c = 0;
    bus_b.rsp_ready = 1'b1;
    bus_b.req_valid = 1'b1;
    bus_b.req_write = 1'b0;
    bus_b.req_addr  = 16'd0;
    for (int c = 0; c < 12; c++) begin
      acc = bus_b.req_ready;
      if (acc) begin
        if (n_acc > 0) check("b2b_spacing", 32'(c - last_c), 32'd3);
        last_c = c;
        n_acc++;
        exp_q.push_back({16'h0, mem_b[nxt]});
      end
      if (bus_b.rsp_valid) begin
        n_rsp++;
        if (exp_q.size() > 0) check("b2b_rdata", {16'h0, bus_b.rsp_rdata}, exp_q.pop_front());
        else check("b2b_extra_rsp", 32'd1, 32'd0);
      end
      @(posedge clk); #1;
      if (acc) begin nxt++; bus_b.req_addr = 16'(nxt % 4); end
    end
    bus_b.req_valid = 1'b0;
    bus_b.rsp_ready = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd4);
    check("b2b_responses", 32'(n_rsp), 32'd4);
    exp_q.delete();

    // Randomized traffic on both instances.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a = a + 32'd256;
      txn_a(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 20; i++) begin
      txn_b(1'($urandom_range(0, 1)), 16'($urandom_range(0, 2 * DEPTH_B - 1)), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
